// File: rtl/vx_pipeline_perf_reader_if.sv
// Request/response channel for reading the pipeline perf counters.
//   master : requester (CSR unit) - drives req_* and rsp_ready
//   slave  : vx_pipeline_perf_reader - drives req_ready and rsp_*
//   req_idx  : counter index; req_hi selects the upper half; req_snap selects the snapshot bank
//   rsp_data : 32-bit read data; rsp_err flags an out-of-range index
interface vx_pipeline_perf_reader_if #(
   parameter int unsigned IDX_W = 6
);
   logic             req_valid;
   logic             req_ready;
   logic [IDX_W-1:0] req_idx;
   logic             req_hi;
   logic             req_snap;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_err;

   modport master (
      output req_valid, req_idx, req_hi, req_snap, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_idx, req_hi, req_snap, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/vx_pipeline_perf_reader.sv
// Consumer end of the pipeline perf-counter bundle. Samples the flattened counters and serves
// 32-bit reads (lo/hi halves, live or snapshot) over a valid/ready request/response channel.
//   clk, reset_n : clock, asynchronous active-low reset
//   perf_ctrs    : live counters, ctr i = perf_ctrs[i*CTR_BITS +: CTR_BITS]
//   snap_take    : copy all live counters into the snapshot bank
//   snap_seq     : number of snapshots taken (wraps)
//   bus          : request/response channel (slave side)
module vx_pipeline_perf_reader #(
   parameter int unsigned NUM_CTRS = 32,
   parameter int unsigned CTR_BITS = 44,
   parameter int unsigned IDX_W    = 6,
   parameter int unsigned SEQ_W    = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_CTRS*CTR_BITS-1:0] perf_ctrs,
   input  logic                         snap_take,
   output logic [SEQ_W-1:0]             snap_seq,
   vx_pipeline_perf_reader_if.slave     bus
);
   localparam int unsigned HI_W = CTR_BITS - 32;
   localparam logic StEmpty = 1'b0;
   localparam logic StFull  = 1'b1;
   // One extra bit so NUM_CTRS == 2**IDX_W still compares correctly.
   localparam logic [IDX_W:0] NumCtrsW = NUM_CTRS[IDX_W:0];

   logic                         state_q, state_d;
   logic [31:0]                  rsp_data_q, rsp_data_d;
   logic                         rsp_err_q, rsp_err_d;
   logic                         shadow_vld_q, shadow_vld_d;
   logic [IDX_W-1:0]             shadow_idx_q, shadow_idx_d;
   logic [HI_W-1:0]              shadow_data_q, shadow_data_d;
   logic [NUM_CTRS*CTR_BITS-1:0] snap_bank_q;
   logic [SEQ_W-1:0]             snap_seq_q;

   logic                req_ready;
   logic                accept;
   logic                idx_ok;
   logic                shadow_hit;
   logic [CTR_BITS-1:0] live_sel;
   logic [CTR_BITS-1:0] snap_sel;

   assign req_ready  = (state_q == StEmpty) | bus.rsp_ready;
   assign accept     = bus.req_valid & req_ready;
   assign idx_ok     = {1'b0, bus.req_idx} < NumCtrsW;
   assign shadow_hit = shadow_vld_q & (shadow_idx_q == bus.req_idx);

   // Constant-index mux keeps out-of-range indices from selecting past the flattened vectors.
   always_comb begin
      live_sel = '0;
      snap_sel = '0;
      for (int i = 0; i < NUM_CTRS; i++) begin
         if (bus.req_idx == IDX_W'(i)) begin
            live_sel = perf_ctrs[i*CTR_BITS +: CTR_BITS];
            snap_sel = snap_bank_q[i*CTR_BITS +: CTR_BITS];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      shadow_vld_d  = shadow_vld_q;
      shadow_idx_d  = shadow_idx_q;
      shadow_data_d = shadow_data_q;
      if (accept) begin
         state_d   = StFull;
         rsp_err_d = 1'b0;
         if (!idx_ok) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
         end else if (bus.req_snap) begin
            rsp_data_d = bus.req_hi ? 32'(snap_sel[CTR_BITS-1:32]) : snap_sel[31:0];
         end else if (!bus.req_hi) begin
            // Latch the upper half now so the following hi read pairs with this lo read.
            rsp_data_d    = live_sel[31:0];
            shadow_vld_d  = 1'b1;
            shadow_idx_d  = bus.req_idx;
            shadow_data_d = live_sel[CTR_BITS-1:32];
         end else if (shadow_hit) begin
            rsp_data_d   = 32'(shadow_data_q);
            shadow_vld_d = 1'b0;
         end else begin
            rsp_data_d = 32'(live_sel[CTR_BITS-1:32]);
         end
      end else if ((state_q == StFull) && bus.rsp_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StEmpty;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         shadow_vld_q  <= 1'b0;
         shadow_idx_q  <= '0;
         shadow_data_q <= '0;
      end else begin
         state_q       <= state_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         shadow_vld_q  <= shadow_vld_d;
         shadow_idx_q  <= shadow_idx_d;
         shadow_data_q <= shadow_data_d;
      end
   end

   // A snap read accepted in the same cycle as snap_take sees the old bank contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_bank_q <= '0;
         snap_seq_q  <= '0;
      end else if (snap_take) begin
         snap_bank_q <= perf_ctrs;
         snap_seq_q  <= snap_seq_q + 1'b1;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = state_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign snap_seq      = snap_seq_q;

endmodule

// File: tb/tb_vx_pipeline_perf_reader.sv
// Self-checking bench for vx_pipeline_perf_reader: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model of the counter reader.
module tb_vx_pipeline_perf_reader;
   localparam int NC = 32;
   localparam int CB = 44;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            snap_take = 1'b0;
   logic [7:0]      snap_seq;
   logic [CB-1:0]   ctr [NC];
   logic [NC*CB-1:0] perf_ctrs;

   vx_pipeline_perf_reader_if #(.IDX_W(6)) bus ();

   vx_pipeline_perf_reader #(
      .NUM_CTRS(NC),
      .CTR_BITS(CB),
      .IDX_W   (6),
      .SEQ_W   (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .perf_ctrs(perf_ctrs),
      .snap_take(snap_take),
      .snap_seq (snap_seq),
      .bus      (bus)
   );

   for (genvar g = 0; g < NC; g++) begin : g_pack
      assign perf_ctrs[g*CB +: CB] = ctr[g];
   end

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   typedef struct {
      int          idx;
      bit          hi;
      bit          snap;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   // Behavioural model state
   logic [CB-1:0] m_bank [NC];
   bit            m_sh_vld;
   int            m_sh_idx;
   logic [11:0]   m_sh_val;
   logic [7:0]    m_seq;
   rsp_t          m_q[$];
   logic [31:0]   got_q[$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_q.delete();
      for (int i = 0; i < NC; i++) m_bank[i] = '0;
      m_sh_vld = 0;
      m_sh_idx = 0;
      m_sh_val = '0;
      m_seq    = '0;
   endfunction

   function automatic void model_read(int idx, bit hi, bit snap, output logic [31:0] d,
                                      output logic e);
      logic [CB-1:0] v;
      d = '0;
      e = 1'b0;
      if (idx >= NC) begin
         e = 1'b1;
      end else begin
         v = snap ? m_bank[idx] : ctr[idx];
         if (!hi) begin
            d = v[31:0];
            if (!snap) begin
               m_sh_vld = 1;
               m_sh_idx = idx;
               m_sh_val = v[CB-1:32];
            end
         end else if (!snap && m_sh_vld && m_sh_idx == idx) begin
            d = 32'(m_sh_val);
            m_sh_vld = 0;
         end else begin
            d = 32'(v >> 32);
         end
      end
   endfunction

   // Called at posedge+1 after inputs are driven; checks, advances the model, crosses one edge.
   task automatic cycle(output bit acc);
      rsp_t        e;
      logic [31:0] d;
      logic        er;
      bit          rr;
      acc = 0;
      #1;
      chk("rsp_valid", bus.rsp_valid, 64'(m_q.size() != 0));
      chk("snap_seq", snap_seq, m_seq);
      rr = (m_q.size() == 0) || bus.rsp_ready;
      chk("req_ready", bus.req_ready, rr);
      if (m_q.size() != 0 && bus.rsp_ready) begin
         e = m_q.pop_front();
         chk("rsp_data", bus.rsp_data, e.data);
         chk("rsp_err", bus.rsp_err, e.err);
         got_q.push_back(bus.rsp_data);
      end
      if (bus.req_valid && rr) begin
         model_read(int'(bus.req_idx), bus.req_hi, bus.req_snap, d, er);
         e.data = d;
         e.err  = er;
         m_q.push_back(e);
         acc = 1;
      end
      if (snap_take) begin
         for (int i = 0; i < NC; i++) m_bank[i] = ctr[i];
         m_seq = m_seq + 8'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(int idx, bit hi, bit snap, bit take, output logic [31:0] d,
                          output logic e);
      bit acc;
      logic [5:0] i6;
      i6 = idx[5:0];
      bus.req_valid = 1'b1;
      bus.req_idx   = i6;
      bus.req_hi    = hi;
      bus.req_snap  = snap;
      bus.rsp_ready = 1'b1;
      snap_take     = take;
      cycle(acc);
      bus.req_valid = 1'b0;
      snap_take     = 1'b0;
      #1;
      d = bus.rsp_data;
      e = bus.rsp_err;
      cycle(acc);
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_idx   = '0;
      bus.req_hi    = 1'b0;
      bus.req_snap  = 1'b0;
      bus.rsp_ready = 1'b1;
      snap_take     = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst rsp_valid", bus.rsp_valid, 0);
         chk("rst snap_seq", snap_seq, 0);
         chk("rst rsp_data", bus.rsp_data, 0);
      end
      model_clear();
      bus.req_valid = 1'b0;
      reset_n       = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        tbl[10];
      logic [31:0] d;
      logic        e;
      bit          acc;
      int          k;

      for (int i = 0; i < NC; i++) ctr[i] = '0;
      model_clear();
      do_reset();

      // Directed vector table
      ctr[5]  = 44'hABC_1234_5678;
      ctr[31] = 44'hFFF_FFFF_FFFF;
      tbl[0] = '{5,  0, 0, 32'h1234_5678, 1'b0};
      tbl[1] = '{5,  1, 0, 32'h0000_0ABC, 1'b0};
      tbl[2] = '{31, 1, 0, 32'h0000_0FFF, 1'b0};
      tbl[3] = '{31, 0, 0, 32'hFFFF_FFFF, 1'b0};
      tbl[4] = '{40, 0, 0, 32'h0,         1'b1};
      tbl[5] = '{32, 1, 0, 32'h0,         1'b1};
      tbl[6] = '{63, 0, 1, 32'h0,         1'b1};
      tbl[7] = '{31, 1, 1, 32'h0,         1'b0};
      tbl[8] = '{31, 1, 0, 32'h0000_0FFF, 1'b0};
      tbl[9] = '{0,  1, 0, 32'h0,         1'b0};
      for (int i = 0; i < 10; i++) begin
         do_read(tbl[i].idx, tbl[i].hi, tbl[i].snap, 1'b0, d, e);
         chk($sformatf("tbl%0d data", i), d, tbl[i].exp_d);
         chk($sformatf("tbl%0d err", i), e, tbl[i].exp_e);
      end

      // Lo/hi pairing across a carry into the upper half
      ctr[3] = 44'h00F_FFFF_FFFF;
      do_read(3, 0, 0, 0, d, e);
      chk("pair lo", d, 32'hFFFF_FFFF);
      ctr[3] = 44'h010_0000_0000;
      do_read(3, 1, 0, 0, d, e);
      chk("pair hi shadow", d, 32'h0000_000F);
      do_read(3, 1, 0, 0, d, e);
      chk("pair hi live", d, 32'h0000_0010);

      // Snapshot bank
      ctr[0] = 44'd100;
      snap_take = 1'b1;
      cycle(acc);
      snap_take = 1'b0;
      ctr[0] = 44'd500;
      do_read(0, 0, 1, 0, d, e);
      chk("snap lo", d, 32'd100);
      chk("snap seq1", snap_seq, 8'd1);
      do_read(0, 0, 0, 0, d, e);
      chk("live after snap", d, 32'd500);
      ctr[0] = 44'd700;
      do_read(0, 0, 1, 1, d, e);
      chk("snap same-cycle old", d, 32'd100);
      do_read(0, 0, 1, 0, d, e);
      chk("snap updated", d, 32'd700);
      chk("snap seq2", snap_seq, 8'd2);

      // Backpressure: three requests, response stalled for four cycles
      ctr[10] = 44'h0AA_0000_1111;
      ctr[11] = 44'h0AA_0000_2222;
      ctr[12] = 44'h0AA_0000_3333;
      got_q.delete();
      k = 0;
      for (int c = 0; c < 20 && (k < 3 || m_q.size() != 0); c++) begin
         bus.req_valid = (k < 3);
         bus.req_idx   = 6'(10 + k);
         bus.req_hi    = 1'b0;
         bus.req_snap  = 1'b0;
         bus.rsp_ready = (c >= 5);
         if (c >= 1 && c <= 4) begin
            #1;
            chk("bp req_ready", bus.req_ready, 0);
            chk("bp data stable", bus.rsp_data, 32'h1111);
         end
         cycle(acc);
         if (acc) k++;
      end
      bus.req_valid = 1'b0;
      chk("bp count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("bp rsp0", got_q[0], 32'h1111);
         chk("bp rsp1", got_q[1], 32'h2222);
         chk("bp rsp2", got_q[2], 32'h3333);
      end

      // Out-of-range read leaves the shadow alone
      ctr[7] = 44'h123_0000_0001;
      do_read(7, 0, 0, 0, d, e);
      chk("oor pre lo", d, 32'h1);
      ctr[7] = 44'h456_0000_0002;
      do_read(32, 0, 0, 0, d, e);
      chk("oor data", d, 32'h0);
      chk("oor err", e, 1'b1);
      do_read(7, 1, 0, 0, d, e);
      chk("oor hi shadow", d, 32'h123);
      chk("oor hi err", e, 1'b0);
      do_read(7, 1, 0, 0, d, e);
      chk("oor hi live", d, 32'h456);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int r;
         int i;
         bus.req_valid = ($urandom_range(0, 3) != 0);
         bus.req_idx   = $urandom_range(0, 1) ? 6'($urandom_range(0, 3))
                                              : 6'($urandom_range(0, 35));
         bus.req_hi    = 1'($urandom_range(0, 1));
         bus.req_snap  = ($urandom_range(0, 3) == 0);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         snap_take     = ($urandom_range(0, 15) == 0);
         r = $urandom_range(0, 9);
         i = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, NC - 1);
         if (r == 0) ctr[i] = {12'($urandom), 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))};
         else if (r < 5) ctr[i] = ctr[i] + 44'($urandom_range(1, 9));
         cycle(acc);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      snap_take     = 1'b0;
      cycle(acc);
      cycle(acc);

      // snap_seq wrap with snap_take held high
      do_reset();
      snap_take = 1'b1;
      for (int c = 0; c < 256; c++) begin
         cycle(acc);
         if (c == 127) chk("seq mid", snap_seq, 8'd128);
      end
      snap_take = 1'b0;
      chk("seq wrap", snap_seq, 8'd0);

      // Asynchronous reset while a response is held
      ctr[1] = 44'h000_0000_00AB;
      bus.req_valid = 1'b1;
      bus.req_idx   = 6'd1;
      bus.req_hi    = 1'b0;
      bus.req_snap  = 1'b0;
      bus.rsp_ready = 1'b0;
      cycle(acc);
      bus.req_valid = 1'b0;
      #1;
      chk("full before rst", bus.rsp_valid, 1);
      chk("full data", bus.rsp_data, 32'hAB);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async rst rsp_valid", bus.rsp_valid, 0);
      chk("async rst rsp_data", bus.rsp_data, 0);
      chk("async rst req_ready", bus.req_ready, 1);
      model_clear();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
